// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: fetch, drain and halt sequencing over a small FIFO.
// Optional IFQ_NOP_FILTER_EN drops opcode-0000 words at fetch instead of queueing them.
module instr_fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int LAST_PC = 15
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] imem_addr,
  input  logic [9:0] imem_data,
  input  logic       stall,
  input  logic       redirect,
  input  logic [3:0] redirect_pc,
  output logic [9:0] ir,
  output logic [3:0] ir_pc,
  output logic       ir_valid,
  output logic       halted
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;
  localparam logic [3:0] LAST = 4'(LAST_PC);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [13:0]   mem_q [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [3:0]    pc_q, pc_d;
  logic [1:0]    st_q, st_d;
  logic          pop, push, adv, nop;
  logic [4:0]    rd_diff;

  assign ir_valid  = (cnt_q != '0);
  assign ir        = ir_valid ? mem_q[rptr_q][13:4] : '0;
  assign ir_pc     = ir_valid ? mem_q[rptr_q][3:0] : '0;
  assign halted    = (st_q == S_HALT);
  assign imem_addr = pc_q;

  // Borrow out means redirect_pc lies beyond the last fetchable address
  assign rd_diff = 5'(LAST_PC) - {1'b0, redirect_pc};

  always_comb begin
    nop = 1'b0;
`ifdef IFQ_NOP_FILTER_EN
    nop = (imem_data[9:6] == 4'd0);
`endif
    pop  = ir_valid && !stall && !redirect;
    push = (st_q == S_FETCH) && !redirect && !nop
           && ((cnt_q != FULL) || pop);
    adv  = push || ((st_q == S_FETCH) && !redirect && nop);
  end

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    pc_d   = pc_q;
    st_d   = st_q;
    if (redirect) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
      pc_d   = redirect_pc;
      st_d   = rd_diff[4] ? S_DRAIN : S_FETCH;
    end else begin
      if (pop)  rptr_d = rptr_q + 1'b1;
      if (push) wptr_d = wptr_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
      // The last address is fetched once; the PC then parks there
      if (adv) begin
        if (pc_q == LAST) st_d = S_DRAIN;
        else              pc_d = pc_q + 1'b1;
      end
      if (st_q == S_DRAIN && cnt_q == '0) st_d = S_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      pc_q   <= '0;
      st_q   <= S_FETCH;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      pc_q   <= pc_d;
      st_q   <= st_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wptr_q] <= {imem_data, imem_addr};
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: directed scenarios push expected
// {ir, ir_pc} pairs; a negedge monitor pops and compares every consumed head.
module tb_instr_fetch_queue;

  logic       clk;
  logic       rst;
  logic [3:0] imem_addr;
  logic [9:0] imem_data;
  logic       stall;
  logic       redirect;
  logic [3:0] redirect_pc;
  logic [9:0] ir;
  logic [3:0] ir_pc;
  logic       ir_valid;
  logic       halted;

  logic [9:0]  pmem [16];
  logic [13:0] sb [$];
  logic [13:0] exp_e;
  int checks;
  int failures;

  instr_fetch_queue #(.DEPTH(4), .LAST_PC(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .halted      (halted)
  );

  assign imem_data = pmem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
`ifdef IFQ_NOP_FILTER_EN
      if (pmem[a][9:6] == 4'd0) continue;
`endif
      sb.push_back({pmem[a], 4'(a)});
    end
  endtask

  task automatic wait_halt(input int max);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < max) begin
      step();
      n++;
    end
    chk("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ir_valid"}, {31'd0, ir_valid}, 32'd0);
    chk({tag, "_ir"}, {22'd0, ir}, 32'd0);
    chk({tag, "_ir_pc"}, {28'd0, ir_pc}, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
    chk({tag, "_imem_addr"}, {28'd0, imem_addr}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && redirect === 1'b0 && stall === 1'b0
        && ir_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra actual=%0h expected=none", {ir, ir_pc});
      end else begin
        exp_e = sb.pop_front();
        chk("ir_seq", {18'd0, ir, ir_pc}, {18'd0, exp_e});
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    for (int a = 0; a < 16; a++)
      pmem[a] = {4'((a % 15) + 1), 6'(a * 7 + 3)};
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 4'd0;

    // Free-running fetch of the whole program
    step();
    rst = 1'b0;
    chk_reset("rst0");
    push_exp(0, 15);
    step();
    chk("first_valid", {31'd0, ir_valid}, 32'd1);
    chk("first_pc", {28'd0, ir_pc}, 32'd0);
    repeat (16) step();
    chk("drain_empty", {31'd0, ir_valid}, 32'd0);
    chk("drain_not_halt", {31'd0, halted}, 32'd0);
    chk("drain_pc_hold", {28'd0, imem_addr}, 32'd15);
    step();
    chk("halt_on_time", {31'd0, halted}, 32'd1);
    repeat (2) step();
    chk("halt_hold", {31'd0, halted}, 32'd1);
    chk("halt_pc_hold", {28'd0, imem_addr}, 32'd15);

    // Stall from reset until the queue saturates
    rst = 1'b1;
    stall = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    chk("sat_addr", {28'd0, imem_addr}, 32'd4);
    chk("sat_pc", {28'd0, ir_pc}, 32'd0);
    chk("sat_valid", {31'd0, ir_valid}, 32'd1);
    chk("sat_ir", {22'd0, ir}, {22'd0, pmem[0]});
    push_exp(0, 4);
    stall = 1'b0;
    step();
    stall = 1'b1;
    chk("full_swap_addr", {28'd0, imem_addr}, 32'd5);
    chk("full_swap_pc", {28'd0, ir_pc}, 32'd1);
    step();
    chk("full_hold_addr", {28'd0, imem_addr}, 32'd5);
    chk("full_hold_pc", {28'd0, ir_pc}, 32'd1);
    stall = 1'b0;
    repeat (4) step();

    // Redirect with three entries queued
    rst = 1'b1;
    stall = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("pre_redir_addr", {28'd0, imem_addr}, 32'd3);
    redirect = 1'b1;
    redirect_pc = 4'd9;
    step();
    redirect = 1'b0;
    stall = 1'b0;
    chk("redir_flush", {31'd0, ir_valid}, 32'd0);
    chk("redir_addr", {28'd0, imem_addr}, 32'd9);
    push_exp(9, 15);
    step();
    chk("redir_valid", {31'd0, ir_valid}, 32'd1);
    chk("redir_pc", {28'd0, ir_pc}, 32'd9);
    wait_halt(20);

    // Reset while draining with two entries queued
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 4'd14;
    step();
    redirect = 1'b0;
    repeat (2) step();
    chk("drain2_addr", {28'd0, imem_addr}, 32'd15);
    chk("drain2_pc", {28'd0, ir_pc}, 32'd14);
    chk("drain2_valid", {31'd0, ir_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("rst_drain");

    // Opcode-0000 word at address 2
    pmem[2] = 10'd0;
    rst = 1'b1;
    stall = 1'b0;
    step();
    rst = 1'b0;
    push_exp(0, 15);
    wait_halt(30);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: prefetch queue entries (power of two, 2..8).
REQ-002 SHALL have parameter LAST_PC, default 15: highest program address fetched before draining.
REQ-003 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port imem_addr  output  4: program memory address (fetch PC).
REQ-006 SHALL have port imem_data  input  10: program memory word, combinational, valid in the same cycle as imem_addr.
REQ-007 SHALL have port stall  input  1: decode not accepting the head instruction this cycle.
REQ-008 SHALL have port redirect  input  1: flush request and fetch-PC reload.
REQ-009 SHALL have port redirect_pc  input  4: new fetch PC, sampled when redirect=1.
REQ-010 SHALL have port ir  output  10: head instruction, opcode in [9:6].
REQ-011 SHALL have port ir_pc  output  4: program address of ir.
REQ-012 SHALL have port ir_valid  output  1: ir/ir_pc hold a queued instruction.
REQ-013 SHALL have port halted  output  1: fetch finished and queue empty.

Function
REQ-014 SHALL use a FIFO of DEPTH entries {instr[9:0], pc[3:0]} with read pointer, write pointer and count of width log2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-015 SHALL drive ir, ir_pc from the head entry, with ir_valid = (count != 0); ir is 0 and ir_pc is 0 when count = 0.
REQ-016 SHALL pop when ir_valid=1 and stall=0.
REQ-017 SHALL push {imem_data, imem_addr} when state=FETCH and (count < DEPTH or a pop occurs in the same cycle); push and pop in one cycle leave count unchanged.
REQ-018 SHALL increment the fetch PC by 1 on each push and SHALL NOT advance it in any cycle without a push.
REQ-019 SHALL implement states FETCH, DRAIN, HALT; FETCH->DRAIN on the push of address LAST_PC; DRAIN->HALT when count reaches 0; HALT holds until redirect or reset.
REQ-020 SHALL keep the fetch PC at LAST_PC in DRAIN and HALT with no wrap to 0.
REQ-021 SHALL assert halted exactly while state=HALT.
REQ-022 SHALL, on redirect=1 in any state, empty the queue, load the fetch PC with redirect_pc, enter FETCH, and suppress that cycle's push and pop; ir_valid SHALL be 0 in the following cycle.
REQ-023 SHALL enter DRAIN directly when redirect_pc > LAST_PC.
REQ-024 SHALL give latency of 1 cycle: an instruction pushed at edge N is visible on ir with ir_valid=1 after edge N when the queue was empty.
REQ-025 SHALL hold ir, ir_pc and queue contents unchanged while stall=1 and the queue is full.

Reset
REQ-026 SHALL, with rst=1 at a clock edge, set state FETCH, fetch PC 0, pointers and count 0, so that ir_valid=0, ir=0, ir_pc=0, halted=0, imem_addr=0.
REQ-027 SHALL give rst priority over redirect, stall and push/pop.
REQ-028 SHALL discard in-flight queue contents on reset mid-operation, with no partial entry retained.

Configuration
REQ-029 SHALL honour macro IFQ_NOP_FILTER_EN: when defined, a fetched word with opcode [9:6]=0000 SHALL advance the fetch PC (and trigger FETCH->DRAIN if at LAST_PC) without being pushed, and SHALL be fetched even when the queue is full.
REQ-030 SHALL, without IFQ_NOP_FILTER_EN, queue 0000-opcode words like any other instruction.

Verification
REQ-031 SHALL cover: reset, stall=0, PMem[0..15]=distinct words -> ir_valid rises after edge 2, ir_pc sequence 0..15 on consecutive cycles, halted=1 two cycles after the pop of pc 15.
REQ-032 SHALL cover: stall=1 for 10 cycles from reset -> count saturates at 4, imem_addr holds 4, ir_pc=0 held; on release ir_pc reads 0,1,2,3,4 with no gaps.
REQ-033 SHALL cover: queue full, stall=0 for one cycle -> simultaneous pop/push, count stays 4, imem_addr steps 4->5.
REQ-034 SHALL cover: redirect=1 with redirect_pc=9 while 3 entries are queued -> next cycle ir_valid=0, imem_addr=9; one cycle later ir_pc=9.
REQ-035 SHALL cover: rst=1 asserted in DRAIN with 2 entries queued -> next cycle all outputs at reset values, imem_addr=0.
REQ-036 SHALL cover, with IFQ_NOP_FILTER_EN defined: PMem[2]=0 -> ir_pc sequence 0,1,3,4, and without it -> 0,1,2,3 with ir=0 at pc 2.
